weight_buffer_reader: RTL and testbench
=======================================

// Module: weight_buffer_reader
// PURPOSE
//  Read-side requester for the B (weight) buffer. Accepts a {base, length} command, issues one row read per cycle to
//  the buffer's fixed-latency read port (no backpressure there), and re-times returning rows into a valid/ready
//  stream for the MM array. A credit-tracked FIFO absorbs in-flight data so downstream stalls never drop a row.
// PARAMETERS
//  BUFFER_ADDR_WIDTH  9    buffer row address width; addresses wrap mod 2**BUFFER_ADDR_WIDTH
//  BUFFER_DATA_WIDTH  512  row width
//  READ_LATENCY       4    cycles from rd_addr_valid to rd_data_valid (buffer's fixed latency)
//  FIFO_DEPTH         8    return FIFO depth; must be >= READ_LATENCY+1 (elaboration error otherwise)
// PORTS
//  clk              in   1     clock
//  rst_n            in   1     asynchronous active-low reset
//  cmd_valid        in   1     command offered
//  cmd_ready        out  1     command accepted when cmd_valid&&cmd_ready
//  cmd_base_addr    in   AW    first row
//  cmd_len          in   AW+1  rows to read, 0..2**AW
//  rd_addr_valid    out  1     read request to buffer (one row)
//  rd_addr          out  AW    request row address
//  rd_data_valid    in   1     returned row valid (READ_LATENCY after request)
//  rd_data          in   DW    returned row
//  out_valid        out  1     stream beat valid
//  out_ready        in   1     stream beat accepted
//  out_data         out  DW    stream data
//  out_last         out  1     final beat of current command
//  done             out  1     1-cycle pulse when last beat accepted (or len==0 command accepted)
//  err_unexpected   out  1     sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: cmd_ready=0 until first clk after release, then 1 in IDLE; rd_addr_valid=0, rd_addr=0, out_valid=0,
//   out_data=0, out_last=0, done=0, err_unexpected=0; FIFO empty, counters 0. Mid-op reset aborts everything;
//   in-flight returns after reset are discarded by the FIFO being cleared only if they arrive during reset.
//  FSM: IDLE -> ISSUE on accept with len>0; IDLE stays (done pulses next cycle) on accept with len==0.
//   ISSUE -> DRAIN when final request issued; DRAIN -> IDLE when last beat accepted (done pulses that cycle+1).
//  cmd_ready=1 only in IDLE; no command overlap.
//  Issue rule: rd_addr_valid=1 (registered) when state==ISSUE and credits>0, credits =
//   FIFO_DEPTH - fifo_count - inflight; inflight = requests issued not yet returned (0..READ_LATENCY).
//  rd_addr = base + issued_count, AW-bit truncation (base=510,len=4 -> 510,511,0,1). rd_addr=0 when not valid.
//  rd_data_valid pushes rd_data into FIFO; simultaneous push+pop keeps count. Credit rule guarantees no overflow.
//  out_valid = FIFO non-empty; out_data = FIFO head (registered output, first-word-fall-through, 0 when empty).
//  out_last = out_valid && beat_count==len-1. Beat accepted on out_valid&&out_ready.
//  Full-rate: with out_ready held 1, len=N command gives first out_valid READ_LATENCY+2 cycles after accept,
//   then N contiguous beats.
// CONFIGURATION
//  WBR_PROTOCOL_CHECK_EN defined: err_unexpected sets (sticky until reset) when rd_data_valid arrives with
//   inflight==0 or with FIFO full; offending row is dropped. Undefined: check logic absent, err_unexpected tied 0,
//   rd_data_valid trusted unconditionally.
// STRUCTURE
//  weight_buf_pkg: READ_LATENCY_DEFAULT constant, typedef enum logic[1:0] {RD_IDLE,RD_ISSUE,RD_DRAIN} rd_state_t.
//  Sub-module wbr_sync_fifo (DEPTH, WIDTH; push/pop/full/empty/count, async reset) holds returned rows.
//  Top holds FSM, issue/inflight/beat counters, credit compare.
// TESTING
//  Bench models buffer as memory with exact READ_LATENCY pipeline, row[i]=i pattern.
//  1 base=0,len=16,out_ready=1 -> rows 0..15 in order, 16 contiguous beats, out_last on beat 15, done once.
//  2 base=510,len=4 -> rd_addr 510,511,0,1; out_data rows 510,511,0,1.
//  3 len=32, out_ready toggles 1 cycle in 3 -> no loss/dup, fifo_count never >FIFO_DEPTH, rd_addr_valid gaps.
//  4 len=0 -> no rd_addr_valid, no out_valid, done pulses once, cmd_ready back to 1.
//  5 rst_n low mid-command (after 5 beats) -> all outputs to reset values; new len=3 command then reads clean.
//  6 (WBR_PROTOCOL_CHECK_EN) inject rd_data_valid in IDLE -> err_unexpected=1 and stays; FIFO unchanged.

Source files
------------

// File: rtl/weight_buf_pkg.sv
// Shared types and constants for the weight (B) buffer read path.
package weight_buf_pkg;

    localparam int READ_LATENCY_DEFAULT = 4;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_DRAIN
    } rd_state_t;

endpackage

// File: rtl/wbr_sync_fifo.sv
// Synchronous FIFO for returned weight rows; first-word-fall-through head read
// straight from storage registers, zero when empty.
module wbr_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 512,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // NOTE: row storage carries no reset; count alone defines which entries are live,
    // so the wide array stays plain flops/RAM without a reset network.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= bump(wr_ptr);
            if (pop_ok)  rd_ptr <= bump(rd_ptr);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/weight_buffer_reader.sv
// Read-side requester for the weight buffer: issues credit-limited row reads and
// streams the returned rows. Optional return checking under WBR_PROTOCOL_CHECK_EN.
module weight_buffer_reader
    import weight_buf_pkg::*;
#(
    parameter int BUFFER_ADDR_WIDTH = 9,
    parameter int BUFFER_DATA_WIDTH = 512,
    parameter int READ_LATENCY      = READ_LATENCY_DEFAULT,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [BUFFER_ADDR_WIDTH:0]   cmd_len,
    output logic                         rd_addr_valid,
    output logic [BUFFER_ADDR_WIDTH-1:0] rd_addr,
    input  logic                         rd_data_valid,
    input  logic [BUFFER_DATA_WIDTH-1:0] rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BUFFER_DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         done,
    output logic                         err_unexpected
);

    localparam int AW = BUFFER_ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0] LEN_ONE = (AW + 1)'(1);

    if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_depth_check
        $error("FIFO_DEPTH must be at least READ_LATENCY+1");
    end

    rd_state_t     state;
    rd_state_t     next_state;
    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [AW:0]   issued_cnt;
    logic [AW:0]   beat_cnt;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   committed;
    logic          fifo_full;
    logic          fifo_empty;
    logic          cmd_fire;
    logic          issue_now;
    logic          beat_fire;
    logic          ret_accept;
    logic          ret_done;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign out_valid = !fifo_empty;
    assign beat_fire = out_valid && out_ready;
    assign out_last  = out_valid && (state != RD_IDLE) && (beat_cnt == len_q - LEN_ONE);

    // Rows already in the FIFO plus rows committed to the buffer must never exceed its depth.
    assign committed = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue_now = (state == RD_ISSUE) && (issued_cnt != len_q)
                    && (committed < (CW + 1)'(FIFO_DEPTH));
    assign ret_done  = ret_accept && (inflight != '0);

`ifdef WBR_PROTOCOL_CHECK_EN
    logic ret_bad;

    assign ret_bad    = rd_data_valid && ((inflight == '0) || fifo_full);
    assign ret_accept = rd_data_valid && !ret_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexpected <= 1'b0;
        end else if (ret_bad) begin
            err_unexpected <= 1'b1;
        end
    end
`else
    logic unused_full;

    assign unused_full    = fifo_full;
    assign ret_accept     = rd_data_valid;
    assign err_unexpected = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state takes its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            RD_IDLE:  if (cmd_fire && (cmd_len != '0)) next_state = RD_ISSUE;
            RD_ISSUE: if (issue_now && (issued_cnt == len_q - LEN_ONE)) next_state = RD_DRAIN;
            RD_DRAIN: if (beat_fire && out_last) next_state = RD_IDLE;
            default:  next_state = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready     <= 1'b0;
            done          <= 1'b0;
            rd_addr_valid <= 1'b0;
            rd_addr       <= '0;
            base_q        <= '0;
            len_q         <= '0;
            issued_cnt    <= '0;
            beat_cnt      <= '0;
            inflight      <= '0;
        end else begin
            cmd_ready     <= (next_state == RD_IDLE);
            done          <= (cmd_fire && (cmd_len == '0)) || (beat_fire && out_last);
            rd_addr_valid <= issue_now;
            rd_addr       <= issue_now ? base_q + issued_cnt[AW-1:0] : '0;

            if (cmd_fire) begin
                base_q     <= cmd_base_addr;
                len_q      <= cmd_len;
                issued_cnt <= '0;
                beat_cnt   <= '0;
            end else begin
                if (issue_now) issued_cnt <= issued_cnt + LEN_ONE;
                if (beat_fire && (state != RD_IDLE)) beat_cnt <= beat_cnt + LEN_ONE;
            end

            // Inflight counts a request from the edge it is committed until its row is pushed.
            unique case ({issue_now, ret_done})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    wbr_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BUFFER_DATA_WIDTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ret_accept),
        .push_data (rd_data),
        .pop       (beat_fire),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_weight_buffer_reader.sv
// Self-checking bench: buffer modelled as row[i]=i behind a fixed-latency pipe,
// expected rows/addresses derived from base+k mod 2**AW.
module tb_weight_buffer_reader;

    localparam int AW = 9;
    localparam int DW = 512;
    localparam int L  = 4;
    localparam int D  = 8;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        int            mode;       // 0: ready held 1, 1: ready 1 cycle in 3, 2: random
        bit            full_rate;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic          rd_addr_valid;
    logic [AW-1:0] rd_addr;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic          err_unexpected;
    logic          inject_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    weight_buffer_reader #(
        .BUFFER_ADDR_WIDTH (AW),
        .BUFFER_DATA_WIDTH (DW),
        .READ_LATENCY      (L),
        .FIFO_DEPTH        (D)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_base_addr  (cmd_base_addr),
        .cmd_len        (cmd_len),
        .rd_addr_valid  (rd_addr_valid),
        .rd_addr        (rd_addr),
        .rd_data_valid  (rd_data_valid),
        .rd_data        (rd_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .done           (done),
        .err_unexpected (err_unexpected)
    );

    // Buffer model: fixed-latency pipe, not reset, row contents equal row index.
    logic [L-1:0]  pv = '0;
    logic [AW-1:0] pa [L];

    always @(posedge clk) begin
        pv    <= {pv[L-2:0], rd_addr_valid};
        pa[0] <= rd_addr;
        for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
    end

    assign rd_data_valid = pv[L-1] || inject_valid;
    assign rd_data       = inject_valid ? {16{32'hDEAD_BEEF}} : DW'(pa[L-1]);

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_int({tag, "_cmd_ready"}, int'(cmd_ready), 0);
        check_int({tag, "_rd_addr_valid"}, int'(rd_addr_valid), 0);
        check_int({tag, "_rd_addr"}, int'(rd_addr), 0);
        check_int({tag, "_out_valid"}, int'(out_valid), 0);
        check_data({tag, "_out_data"}, out_data, '0);
        check_int({tag, "_out_last"}, int'(out_last), 0);
        check_int({tag, "_done"}, int'(done), 0);
        check_int({tag, "_err"}, int'(err_unexpected), 0);
    endtask

    // Called at a negedge; returns at the first negedge after the accepting edge.
    task automatic send_cmd(input logic [AW-1:0] b, input logic [AW:0] l);
        int w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_int("cmd_ready_wait", int'(cmd_ready), 1);
        cmd_base_addr = b;
        cmd_len       = l;
        cmd_valid     = 1'b1;
        @(negedge clk);
        cmd_valid     = 1'b0;
        cmd_base_addr = '0;
        cmd_len       = '0;
    endtask

    task automatic run_cmd(input vec_t v);
        logic [AW-1:0] exp_addr [$];
        logic [AW-1:0] exp_row [$];
        logic [AW-1:0] r;
        int cyc = 0;
        int budget;
        int beats = 0;
        int issues = 0;
        int dones = 0;
        int done_cyc = -1;
        int first_v = -1;
        int last_fire = -1;
        int first_iss = -1;
        int last_iss = -1;
        int tail = 0;

        for (int k = 0; k < int'(v.len); k++) begin
            r = AW'((int'(v.base) + k) % (1 << AW));
            exp_addr.push_back(r);
            exp_row.push_back(r);
        end
        budget = 4 * int'(v.len) + 60;
        send_cmd(v.base, v.len);

        while (cyc < budget) begin
            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check_int("done_timing", cyc, (v.len == 0) ? 0 : last_fire + 1);
                end
            end
            if (cyc == 1 && v.len != 0) check_int("cmd_ready_busy", int'(cmd_ready), 0);
            if (rd_addr_valid) begin
                issues++;
                if (first_iss < 0) first_iss = cyc;
                last_iss = cyc;
                if (exp_addr.size() > 0) check_int("rd_addr", int'(rd_addr), int'(exp_addr.pop_front()));
                else check_int("extra_request", int'(rd_addr_valid), 0);
            end

            case (v.mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase

            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (exp_row.size() > 0) begin
                    check_data("out_data", out_data, DW'(exp_row[0]));
                    check_int("out_last", int'(out_last), int'(exp_row.size() == 1));
                    if (out_ready) begin
                        void'(exp_row.pop_front());
                        beats++;
                        last_fire = cyc;
                    end
                end else begin
                    check_int("extra_beat", int'(out_valid), 0);
                end
            end else begin
                check_data("out_data_empty", out_data, '0);
            end

            if (done_cyc >= 0) tail++;
            if (tail > L + 3) break;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;

        check_int("cmd_complete", int'(done_cyc >= 0 && exp_row.size() == 0 && exp_addr.size() == 0), 1);
        check_int("beat_count", beats, int'(v.len));
        check_int("issue_count", issues, int'(v.len));
        check_int("done_once", dones, 1);
        check_int("cmd_ready_after", int'(cmd_ready), 1);
        check_int("err_clear", int'(err_unexpected), 0);
        if (v.full_rate && v.len != 0) begin
            check_int("first_valid_latency", first_v, L + 2);
            check_int("contiguous_beats", last_fire - first_v, int'(v.len) - 1);
        end
        if (v.len == 0) check_int("no_out_valid", first_v, -1);
        if (v.mode == 1 && v.len > 1) check_int("issue_gaps", int'(last_iss - first_iss + 1 > int'(v.len)), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int w;

        vecs[0] = '{base: 9'd0,   len: 10'd16,  mode: 0, full_rate: 1'b1};
        vecs[1] = '{base: 9'd510, len: 10'd4,   mode: 0, full_rate: 1'b1};
        vecs[2] = '{base: 9'd37,  len: 10'd32,  mode: 1, full_rate: 1'b0};
        vecs[3] = '{base: 9'd5,   len: 10'd0,   mode: 0, full_rate: 1'b0};
        vecs[4] = '{base: 9'd511, len: 10'd1,   mode: 0, full_rate: 1'b1};
        vecs[5] = '{base: AW'($urandom_range(0, 511)), len: (AW + 1)'($urandom_range(1, 40)), mode: 2, full_rate: 1'b0};
        vecs[6] = '{base: AW'($urandom_range(0, 511)), len: 10'd512, mode: 0, full_rate: 1'b1};
        vecs[7] = '{base: AW'($urandom_range(0, 511)), len: (AW + 1)'($urandom_range(1, 40)), mode: 2, full_rate: 1'b0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        check_int("cmd_ready_before_clk", int'(cmd_ready), 0);
        @(negedge clk);
        check_int("cmd_ready_after_release", int'(cmd_ready), 1);

        for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

        // Abort a command after five beats, then confirm a fresh command reads clean.
        send_cmd(9'd200, 10'd20);
        beats = 0;
        w = 0;
        while (beats < 5 && w < 100) begin
            if (out_valid) begin
                check_data("abort_data", out_data, DW'(200 + beats));
                beats++;
            end
            if (beats < 5) begin
                @(negedge clk);
                w++;
            end
        end
        check_int("abort_beats_seen", beats, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (8) @(negedge clk);
        check_int("midreset_hold_cmd_ready", int'(cmd_ready), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_int("post_reset_out_valid", int'(out_valid), 0);
        run_cmd('{base: 9'd300, len: 10'd3, mode: 0, full_rate: 1'b1});

`ifdef WBR_PROTOCOL_CHECK_EN
        inject_valid = 1'b1;
        @(negedge clk);
        inject_valid = 1'b0;
        check_int("err_set", int'(err_unexpected), 1);
        check_int("err_row_dropped", int'(out_valid), 0);
        repeat (5) @(negedge clk);
        check_int("err_sticky", int'(err_unexpected), 1);
        check_int("err_fifo_unchanged", int'(out_valid), 0);
        rst_n = 1'b0;
        #1;
        check_int("err_cleared_by_reset", int'(err_unexpected), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
